// File: rtl/gp_reg_bank.sv
// General-purpose register bank: two combinational read ports, one write port,
// per-register dirty flags and a handshaked dump engine. Optional macro GP_REG_BANK_BYPASS_EN.
module gp_reg_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rd_addr_1,
    input  logic [ADDR_W-1:0]        rd_addr_2,
    output logic [DATA_W-1:0]        rd_data_1,
    output logic [DATA_W-1:0]        rd_data_2,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     dump_req,
    input  logic                     dump_dirty_only,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_busy,
    output logic                     dump_done,
    output logic [(2**ADDR_W)-1:0]   dirty
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  dirty_q;
    logic [DEPTH-1:0]  dirty_d;
    logic [DEPTH-1:0]  clr_s;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic              mode_q;
    logic              mode_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              include_s;
    logic              accept_s;

    assign include_s = (~mode_q) | dirty_q[idx_q];
    assign accept_s  = valid_q & dump_ready;

    // Dump FSM next-state and beat capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    state_d = ST_SCAN;
                    idx_d   = IDX_ZERO;
                    mode_d  = dump_dirty_only;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (include_s) begin
                    // Array read here is pre-write, so a colliding write is not captured
                    data_d  = regs_q[idx_q];
                    addr_d  = idx_q;
                    state_d = ST_SEND;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                end
            end
            ST_SEND: begin
                if (accept_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Dirty clear request for the register being captured
    always_comb begin
        clr_s = {DEPTH{1'b0}};
        if ((state_q == ST_SCAN) && include_s) begin
            clr_s[idx_q] = 1'b1;
        end else begin
            clr_s = {DEPTH{1'b0}};
        end
    end

    // Array and dirty next state; a write sets its flag even when cleared the same cycle
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i]  = (wr_en && (wr_addr == ADDR_W'(i))) ? wr_data : regs_q[i];
            dirty_d[i] = (wr_en && (wr_addr == ADDR_W'(i))) | (dirty_q[i] & ~clr_s[i]);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            dirty_q <= {DEPTH{1'b0}};
            state_q <= ST_IDLE;
            idx_q   <= IDX_ZERO;
            mode_q  <= 1'b0;
            addr_q  <= IDX_ZERO;
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dirty_q <= dirty_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= (state_d == ST_SEND);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

`ifdef GP_REG_BANK_BYPASS_EN
    assign rd_data_1 = (wr_en && (wr_addr == rd_addr_1)) ? wr_data : regs_q[rd_addr_1];
    assign rd_data_2 = (wr_en && (wr_addr == rd_addr_2)) ? wr_data : regs_q[rd_addr_2];
`else
    assign rd_data_1 = regs_q[rd_addr_1];
    assign rd_data_2 = regs_q[rd_addr_2];
`endif

    assign dump_valid = valid_q;
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;
    assign dirty      = dirty_q;

endmodule
